// File: rtl/store_buffer_if.sv
// Store buffer bus: core store/load handshakes plus the single data-memory port.
interface store_buffer_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) ();
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_resp_valid;
    logic [DATA_W-1:0] ld_resp_data;
    logic              empty;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, mem_read_data,
        input  st_ready, ld_ready, ld_resp_valid, ld_resp_data, empty,
               mem_read, mem_write, mem_address, mem_write_data
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, mem_read_data,
        output st_ready, ld_ready, ld_resp_valid, ld_resp_data, empty,
               mem_read, mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/store_buffer.sv
// Halfword store FIFO in front of a 16-bit big-endian data memory with load forwarding.
// Define STORE_BUF_COALESCE_EN to merge a store into the youngest entry at the same address.
module store_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    store_buffer_if.slave bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0]  ent_valid;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              resp_valid_q;
    logic              resp_miss_q;
    logic [DATA_W-1:0] fwd_q;

    logic              full;
    logic              push;
    logic              alloc;
    logic              pop;
    logic              coalesce;
    logic              conflict;
    logic              hit;
    logic              ld_acc;
    logic              rd;
    logic [DATA_W-1:0] hit_data;
    logic [ADDR_W-1:0] ld_lo;
    logic [ADDR_W-1:0] ld_hi;
    logic [PTR_W-1:0]  scan_idx;
    logic [PTR_W-1:0]  youngest;

    always_comb begin
        full     = (count == CNT_W'(DEPTH));
        push     = bus.st_valid && !full;
        ld_lo    = bus.ld_addr - ADDR_W'(1);
        ld_hi    = bus.ld_addr + ADDR_W'(1);
        hit      = 1'b0;
        hit_data = '0;
        conflict = 1'b0;
        scan_idx = '0;
        // Scan oldest to youngest so the last exact match is the youngest one.
        for (int i = 0; i < int'(DEPTH); i++) begin
            scan_idx = head + PTR_W'(i);
            if (ent_valid[scan_idx]) begin
                if (ent_addr[scan_idx] == bus.ld_addr) begin
                    hit      = 1'b1;
                    hit_data = ent_data[scan_idx];
                end
                if ((ent_addr[scan_idx] == ld_lo) || (ent_addr[scan_idx] == ld_hi)) begin
                    conflict = 1'b1;
                end
            end
        end
        // A store pushed this cycle is younger than every buffered entry.
        if (push) begin
            if (bus.st_addr == bus.ld_addr) begin
                hit      = 1'b1;
                hit_data = bus.st_data;
            end
            if ((bus.st_addr == ld_lo) || (bus.st_addr == ld_hi)) begin
                conflict = 1'b1;
            end
        end

        ld_acc   = bus.ld_valid && !full && !conflict;
        rd       = rst_n && ld_acc && !hit;
        pop      = rst_n && !rd && (count != '0);
        youngest = tail - PTR_W'(1);
        coalesce = 1'b0;
`ifdef STORE_BUF_COALESCE_EN
        // The head entry being written this cycle cannot be merged into.
        coalesce = push && (count != '0) && (ent_addr[youngest] == bus.st_addr)
                   && !(pop && (youngest == head));
`endif
        alloc    = push && !coalesce;
    end

    assign bus.st_ready       = !full;
    assign bus.ld_ready       = !full && !conflict;
    assign bus.empty          = (count == '0);
    assign bus.mem_read       = rd;
    assign bus.mem_write      = pop;
    assign bus.mem_address    = rd ? bus.ld_addr : (pop ? ent_addr[head] : '0);
    assign bus.mem_write_data = pop ? ent_data[head] : '0;
    assign bus.ld_resp_valid  = resp_valid_q;
    assign bus.ld_resp_data   = resp_miss_q ? bus.mem_read_data : fwd_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            ent_valid    <= '0;
            resp_valid_q <= 1'b0;
            resp_miss_q  <= 1'b0;
            fwd_q        <= '0;
        end else begin
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PTR_W'(1);
            end
            if (coalesce) begin
                ent_data[youngest] <= bus.st_data;
            end else if (alloc) begin
                ent_addr[tail]  <= bus.st_addr;
                ent_data[tail]  <= bus.st_data;
                ent_valid[tail] <= 1'b1;
                tail            <= tail + PTR_W'(1);
            end
            count        <= count + CNT_W'(alloc) - CNT_W'(pop);
            resp_valid_q <= ld_acc;
            resp_miss_q  <= rd;
            if (ld_acc && hit) begin
                fwd_q <= hit_data;
            end
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: program-order memory model plus write/response scoreboards.
module tb_store_buffer;
    localparam int unsigned MEM_BYTES = 1024;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;

    store_buffer_if #(.ADDR_W(16), .DATA_W(16)) sbi ();

    store_buffer #(.DEPTH(4), .ADDR_W(16), .DATA_W(16)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (sbi)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  phys    [MEM_BYTES];
    logic [7:0]  ref_mem [MEM_BYTES];
    wr_t         wq[$];
    logic [15:0] lq[$];
    logic        resp_due   = 1'b0;
    logic        merge_hint = 1'b0;

    logic        s_st_ready, s_ld_ready, s_empty, s_mem_read, s_mem_write, s_resp_valid;
    logic [15:0] s_mem_address, s_resp_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, score, record handshakes, then step past the posedge.
    task automatic cycle();
        logic        st_acc;
        logic        ld_acc;
        logic        rst_seen;
        logic        rd_pend;
        logic [15:0] rd_val;
        int          a;
        wr_t         w;
        ld_acc = 1'b0;
        rd_val = 16'h0;
        @(negedge clk);
        s_st_ready    = sbi.st_ready;
        s_ld_ready    = sbi.ld_ready;
        s_empty       = sbi.empty;
        s_mem_read    = sbi.mem_read;
        s_mem_write   = sbi.mem_write;
        s_mem_address = sbi.mem_address;
        s_resp_valid  = sbi.ld_resp_valid;
        s_resp_data   = sbi.ld_resp_data;
        rst_seen      = rst_n;

        check("port_exclusive", 32'(s_mem_read && s_mem_write), 32'd0);
        if (!rst_seen) begin
            check("reset_write", 32'(s_mem_write), 32'd0);
        end else begin
            check("resp_valid", 32'(s_resp_valid), 32'(resp_due));
            if (s_resp_valid && lq.size() != 0) begin
                check("resp_data", 32'(s_resp_data), 32'(lq.pop_front()));
            end
        end
        if (s_mem_write === 1'b1) begin
            if (wq.size() == 0) begin
                check("write_without_store", 32'(s_mem_write), 32'd0);
            end else begin
                w = wq.pop_front();
                check("write_addr", 32'(s_mem_address), 32'(w.addr));
                check("write_data", 32'(sbi.mem_write_data), 32'(w.data));
            end
            a = int'(s_mem_address[9:0]);
            phys[a]     = sbi.mem_write_data[15:8];
            phys[a + 1] = sbi.mem_write_data[7:0];
        end
        rd_pend = s_mem_read;
        if (rd_pend) begin
            a      = int'(s_mem_address[9:0]);
            rd_val = {phys[a], phys[a + 1]};
        end
        if (rst_seen) begin
            st_acc = sbi.st_valid && s_st_ready;
            ld_acc = sbi.ld_valid && s_ld_ready;
            if (st_acc) begin
                a              = int'(sbi.st_addr[9:0]);
                ref_mem[a]     = sbi.st_data[15:8];
                ref_mem[a + 1] = sbi.st_data[7:0];
                if (merge_hint && wq.size() != 0) wq[wq.size() - 1] = '{sbi.st_addr, sbi.st_data};
                else wq.push_back('{sbi.st_addr, sbi.st_data});
            end
            if (ld_acc) begin
                a = int'(sbi.ld_addr[9:0]);
                lq.push_back({ref_mem[a], ref_mem[a + 1]});
            end
        end
        @(posedge clk);
        #1;
        if (rd_pend) sbi.mem_read_data = rd_val;
        resp_due = ld_acc;
        if (!rst_seen) begin
            wq.delete();
            lq.delete();
            for (int i = 0; i < int'(MEM_BYTES); i++) ref_mem[i] = phys[i];
        end
    endtask

    task automatic idle();
        sbi.st_valid = 1'b0;
        sbi.ld_valid = 1'b0;
    endtask

    task automatic push_st(input logic [15:0] addr, input logic [15:0] data);
        sbi.st_valid = 1'b1;
        sbi.st_addr  = addr;
        sbi.st_data  = data;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        idle();
        do begin
            cycle();
            n++;
        end while (!s_empty && n < 20);
        check(tag, 32'(s_empty), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall;
        int mism;
        logic acc;

        for (int i = 0; i < int'(MEM_BYTES); i++) begin
            phys[i]    = 8'(i) ^ 8'h3C;
            ref_mem[i] = 8'(i) ^ 8'h3C;
        end
        rst_n = 1'b0;
        sbi.st_valid = 1'b0; sbi.st_addr = '0; sbi.st_data = '0;
        sbi.ld_valid = 1'b0; sbi.ld_addr = '0; sbi.mem_read_data = '0;
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        check("reset_empty", 32'(s_empty), 32'd1);
        check("reset_st_ready", 32'(s_st_ready), 32'd1);
        check("reset_ld_ready", 32'(s_ld_ready), 32'd1);
        check("reset_resp_valid", 32'(s_resp_valid), 32'd0);
        check("reset_resp_data", 32'(s_resp_data), 32'd0);

        // Three stores drain in push order.
        push_st(16'h0010, 16'hABCD); cycle(); check("t1_st_ready_a", 32'(s_st_ready), 32'd1);
        push_st(16'h0020, 16'h1234); cycle(); check("t1_st_ready_b", 32'(s_st_ready), 32'd1);
        push_st(16'h0030, 16'h00FF); cycle(); check("t1_st_ready_c", 32'(s_st_ready), 32'd1);
        drain("t1_empty");
        check("t1_writes_done", 32'(wq.size()), 32'd0);

        // Same-cycle store forwards to the load.
        push_st(16'h0040, 16'hBEEF);
        sbi.ld_valid = 1'b1; sbi.ld_addr = 16'h0040;
        cycle();
        check("t2_ld_ready", 32'(s_ld_ready), 32'd1);
        check("t2_no_read", 32'(s_mem_read), 32'd0);
        idle(); cycle();
        check("t2_resp_valid", 32'(s_resp_valid), 32'd1);
        check("t2_resp_data", 32'(s_resp_data), 32'h0000_BEEF);
        check("t2_no_read_after", 32'(s_mem_read), 32'd0);
        drain("t2_empty");

        // Youngest exact match wins while drains are blocked by miss loads.
        sbi.ld_valid = 1'b1; sbi.ld_addr = 16'h0100;
        push_st(16'h0050, 16'h1111); cycle();
        check("t3_read_a", 32'(s_mem_read), 32'd1);
`ifdef STORE_BUF_COALESCE_EN
        merge_hint = 1'b1;
`endif
        push_st(16'h0050, 16'h2222); cycle();
        merge_hint = 1'b0;
        check("t3_write_blocked", 32'(s_mem_write), 32'd0);
        sbi.st_valid = 1'b0; sbi.ld_addr = 16'h0050; cycle();
        check("t3_hit_ready", 32'(s_ld_ready), 32'd1);
        check("t3_hit_no_read", 32'(s_mem_read), 32'd0);
        idle(); cycle();
        check("t3_resp_data", 32'(s_resp_data), 32'h0000_2222);
        drain("t3_empty");

        // Partial overlap stalls the load until the conflicting store is written.
        push_st(16'h0060, 16'hA5A5); cycle();
        sbi.st_valid = 1'b0;
        sbi.ld_valid = 1'b1; sbi.ld_addr = 16'h0061;
        stall = 0; acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) begin
            cycle();
            if (s_ld_ready) acc = 1'b1;
            else begin
                stall++;
                check("t4_stall_write", 32'(s_mem_write), 32'd1);
                check("t4_stall_addr", 32'(s_mem_address), 32'h0000_0060);
            end
        end
        check("t4_accepted", 32'(acc), 32'd1);
        check("t4_stall_cycles", 32'(stall), 32'd1);
        check("t4_mem_read", 32'(s_mem_read), 32'd1);
        check("t4_read_addr", 32'(s_mem_address), 32'h0000_0061);
        idle(); cycle();
        check("t4_resp_valid", 32'(s_resp_valid), 32'd1);
        check("t4_resp_hi", 32'(s_resp_data[15:8]), 32'h0000_00A5);
        drain("t4_empty");

        // Fill to DEPTH behind miss loads, then one slot frees.
        sbi.ld_valid = 1'b1; sbi.ld_addr = 16'h0200;
        for (int i = 0; i < 4; i++) begin
            push_st(16'h0300 + 16'(2 * i), 16'h5000 + 16'(i));
            cycle();
            check("t5_st_ready", 32'(s_st_ready), 32'd1);
            check("t5_blocked", 32'(s_mem_write), 32'd0);
        end
        sbi.st_valid = 1'b0; cycle();
        check("t5_full_st_ready", 32'(s_st_ready), 32'd0);
        check("t5_full_ld_ready", 32'(s_ld_ready), 32'd0);
        check("t5_full_write", 32'(s_mem_write), 32'd1);
        check("t5_full_addr", 32'(s_mem_address), 32'h0000_0300);
        idle(); cycle();
        check("t5_st_ready_back", 32'(s_st_ready), 32'd1);
        drain("t5_empty");

        // Reset discards pending stores and the in-flight response.
        sbi.ld_valid = 1'b1; sbi.ld_addr = 16'h0100;
        push_st(16'h0070, 16'h7777); cycle();
        push_st(16'h0072, 16'h7272); cycle();
        check("t6_pending", 32'(s_empty), 32'd0);
        idle(); rst_n = 1'b0; cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t6_no_write", 32'(s_mem_write), 32'd0);
            check("t6_empty", 32'(s_empty), 32'd1);
            check("t6_resp_valid", 32'(s_resp_valid), 32'd0);
        end

        check("end_write_queue", 32'(wq.size()), 32'd0);
        check("end_load_queue", 32'(lq.size()), 32'd0);
        mism = 0;
        for (int i = 0; i < int'(MEM_BYTES); i++) if (phys[i] !== ref_mem[i]) mism++;
        check("mem_consistency", 32'(mism), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
